// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU codes,
// T-step/state encoding, instruction classes and the control-word layout.
package cpu_defs_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                         OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                         OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHL  = 5'b01000,
                         OP_ROR  = 5'b01001, OP_ROL  = 5'b01010, OP_NEG  = 5'b01011,
                         OP_NOT  = 5'b01100, OP_ADDI = 5'b01101, OP_ANDI = 5'b01110,
                         OP_ORI  = 5'b01111, OP_MUL  = 5'b10000, OP_DIV  = 5'b10001,
                         OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_JAL  = 5'b10100,
                         OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111,
                         OP_MFLO = 5'b11000, OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

  // ALU code used for address and PC arithmetic
  localparam logic [4:0] ALU_ADD = 5'b00011;

  // Externally visible sequencer state; T-steps occupy 0..7
  typedef enum logic [3:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    ST_RESET, ST_HALT, ST_STOPPED
  } state_t;

  // Sequencer mode; the T-step itself lives in the step counter
  typedef enum logic [1:0] {MD_RESET, MD_RUN, MD_HALT, MD_STOPPED} mode_t;

  typedef enum logic [3:0] {
    CL_RTYPE, CL_UNARY, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } iclass_t;

  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, hiout, loout, cout, inportout, baout, rout;
    logic marin, mdrin, irin, yin, zin, pcin, hiin, loin, rin, conin, outportin;
    logic gra, grb, grc, incpc, read, write;
    logic [4:0] op;
    logic run;
  } ctl_t;

  function automatic iclass_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CL_RTYPE;
      OP_NEG, OP_NOT:                 return CL_UNARY;
      OP_ADDI, OP_ANDI, OP_ORI:       return CL_IMM;
      OP_LDI:                         return CL_LDI;
      OP_LD:                          return CL_LD;
      OP_ST:                          return CL_ST;
      OP_MUL, OP_DIV:                 return CL_MULDIV;
      OP_BR:                          return CL_BR;
      OP_JR:                          return CL_JR;
      OP_JAL:                         return CL_JAL;
      OP_IN:                          return CL_IN;
      OP_OUT:                         return CL_OUT;
      OP_MFHI:                        return CL_MFHI;
      OP_MFLO:                        return CL_MFLO;
      OP_HALT:                        return CL_HALT;
      default:                        return CL_NOP;
    endcase
  endfunction

  // Final T-step of each class; the counter wraps to T0 after it
  function automatic logic [3:0] last_step(input iclass_t c);
    case (c)
      CL_RTYPE, CL_IMM, CL_LDI: return 4'd5;
      CL_UNARY, CL_JAL:         return 4'd4;
      CL_MULDIV, CL_BR:         return 4'd6;
      CL_LD, CL_ST:             return 4'd7;
      default:                  return 4'd3;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath control bundle. The sequencer is the master.
interface control_sequencer_if #(parameter int IRW = 32, parameter int OPW = 5);
  logic           Stop;
  logic [IRW-1:0] IR;
  logic           CON_FF;
  logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout, BAout, Rout;
  logic MARin, MDRin, IRin, Yin, Zin, PCin, HIin, LOin, Rin, CONin, OutPortin;
  logic Gra, Grb, Grc, IncPC, Read, Write;
  logic [OPW-1:0] operation;
  logic Run;

  modport master (
    input  Stop, IR, CON_FF,
    output PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout, BAout, Rout,
           MARin, MDRin, IRin, Yin, Zin, PCin, HIin, LOin, Rin, CONin, OutPortin,
           Gra, Grb, Grc, IncPC, Read, Write, operation, Run
  );

  modport slave (
    output Stop, IR, CON_FF,
    input  PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout, BAout, Rout,
           MARin, MDRin, IRin, Yin, Zin, PCin, HIin, LOin, Rin, CONin, OutPortin,
           Gra, Grb, Grc, IncPC, Read, Write, operation, Run
  );
endinterface

// File: rtl/step_counter.sv
// 4-bit T-step counter: clears synchronously, otherwise advances every clock.
module step_counter (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       i_clr,
  output logic [3:0] o_cnt
);
  logic [3:0] r_cnt;

  // count T-steps, restart at T0 on reset or clear
  always_ff @(posedge Clock) begin
    if (Reset || i_clr) r_cnt <= '0;
    else                r_cnt <= r_cnt + 4'd1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch T0-T2, opcode-specific T3-T7.
// Outputs are decoded from the registered mode/T-step and the live opcode.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input logic                 Clock,
  input logic                 Reset,
  control_sequencer_if.master bus
);
  mode_t          r_mode;
  logic [3:0]     w_step;
  logic [OPW-1:0] w_opc;
  iclass_t        w_cls;
  state_t         w_state;
  logic           w_last, w_clr, w_ir_unused;
  ctl_t           w_c;
  logic [9:0]     w_drv;

  assign w_opc       = bus.IR[IRW-1 -: OPW];
  assign w_ir_unused = ^bus.IR[IRW-OPW-1:0];
  assign w_cls       = classify(w_opc);
  // last_step() is never below 3, so a not-yet-loaded IR cannot end fetch early
  assign w_last      = (r_mode == MD_RUN) && (w_step == last_step(w_cls));
  assign w_clr       = (r_mode != MD_RUN) || w_last;

  step_counter u_step (.Clock(Clock), .Reset(Reset), .i_clr(w_clr), .o_cnt(w_step));

  // map mode + T-step onto the visible state encoding
  always_comb begin
    case (r_mode)
      MD_RUN:  w_state = state_t'({1'b0, w_step[2:0]});
      MD_HALT: w_state = ST_HALT;
      MD_STOPPED: w_state = ST_STOPPED;
      default: w_state = ST_RESET;
    endcase
  end

  // mode FSM: Reset dominates, halt/Stop only take effect at an instruction boundary
  always_ff @(posedge Clock) begin
    if (Reset) r_mode <= MD_RESET;
    else begin
      case (r_mode)
        MD_RESET: r_mode <= MD_RUN;
        MD_RUN: if (w_last) begin
          if (w_cls == CL_HALT) r_mode <= MD_HALT;
          else if (bus.Stop)    r_mode <= MD_STOPPED;
        end
        MD_STOPPED: if (!bus.Stop) r_mode <= MD_RUN;
        default: r_mode <= r_mode;
      endcase
    end
  end

  // output decode table
  always_comb begin
    w_c     = '0;
    w_c.run = (r_mode == MD_RESET) || (r_mode == MD_RUN);
    case (w_state)
      ST_T0: begin w_c.pcout = 1'b1; w_c.marin = 1'b1; w_c.incpc = 1'b1; w_c.zin = 1'b1; end
      ST_T1: begin w_c.zlowout = 1'b1; w_c.pcin = 1'b1; w_c.read = 1'b1; w_c.mdrin = 1'b1; end
      ST_T2: begin w_c.mdrout = 1'b1; w_c.irin = 1'b1; end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        case (w_cls)
          CL_RTYPE: case (w_state)
            ST_T3: begin w_c.grb = 1'b1; w_c.rout = 1'b1; w_c.yin = 1'b1; end
            ST_T4: begin w_c.grc = 1'b1; w_c.rout = 1'b1; w_c.op = w_opc; w_c.zin = 1'b1; end
            ST_T5: begin w_c.zlowout = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; end
            default: ;
          endcase
          CL_UNARY: case (w_state)
            ST_T3: begin w_c.grb = 1'b1; w_c.rout = 1'b1; w_c.op = w_opc; w_c.zin = 1'b1; end
            ST_T4: begin w_c.zlowout = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; end
            default: ;
          endcase
          // BAout makes R0 read as zero for the base-address forms
          CL_IMM, CL_LDI, CL_LD, CL_ST: case (w_state)
            ST_T3: begin w_c.grb = 1'b1; w_c.baout = 1'b1; w_c.yin = 1'b1; end
            ST_T4: begin
              w_c.cout = 1'b1; w_c.zin = 1'b1;
              w_c.op   = (w_cls == CL_IMM) ? w_opc : ALU_ADD;
            end
            ST_T5: begin
              w_c.zlowout = 1'b1;
              if (w_cls == CL_LD || w_cls == CL_ST) w_c.marin = 1'b1;
              else begin w_c.gra = 1'b1; w_c.rin = 1'b1; end
            end
            ST_T6: begin
              w_c.mdrin = 1'b1;
              if (w_cls == CL_LD) w_c.read = 1'b1;
              else begin w_c.gra = 1'b1; w_c.rout = 1'b1; end
            end
            ST_T7: begin
              if (w_cls == CL_LD) begin w_c.mdrout = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; end
              else w_c.write = 1'b1;
            end
            default: ;
          endcase
          CL_MULDIV: case (w_state)
            ST_T3: begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.yin = 1'b1; end
            ST_T4: begin w_c.grb = 1'b1; w_c.rout = 1'b1; w_c.op = w_opc; w_c.zin = 1'b1; end
            ST_T5: begin w_c.zlowout = 1'b1; w_c.loin = 1'b1; end
            ST_T6: begin w_c.zhighout = 1'b1; w_c.hiin = 1'b1; end
            default: ;
          endcase
          // CON_FF was latched by CONin at T3, so reading it at T6 stays Moore
          CL_BR: case (w_state)
            ST_T3: begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.conin = 1'b1; end
            ST_T4: begin w_c.pcout = 1'b1; w_c.yin = 1'b1; end
            ST_T5: begin w_c.cout = 1'b1; w_c.op = ALU_ADD; w_c.zin = 1'b1; end
            ST_T6: begin w_c.zlowout = 1'b1; w_c.pcin = bus.CON_FF; end
            default: ;
          endcase
          CL_JR: if (w_state == ST_T3) begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.pcin = 1'b1; end
          // R15 is selected by the datapath when Rin fires with no Gr* select
          CL_JAL: case (w_state)
            ST_T3: begin w_c.pcout = 1'b1; w_c.rin = 1'b1; end
            ST_T4: begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.pcin = 1'b1; end
            default: ;
          endcase
          CL_IN:   if (w_state == ST_T3) begin w_c.inportout = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; end
          CL_OUT:  if (w_state == ST_T3) begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.outportin = 1'b1; end
          CL_MFHI: if (w_state == ST_T3) begin w_c.hiout = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; end
          CL_MFLO: if (w_state == ST_T3) begin w_c.loout = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.PCout = w_c.pcout;     assign bus.Zlowout = w_c.zlowout;
  assign bus.ZHighout = w_c.zhighout; assign bus.MDRout = w_c.mdrout;
  assign bus.HIout = w_c.hiout;     assign bus.LOout = w_c.loout;
  assign bus.Cout = w_c.cout;       assign bus.InPortout = w_c.inportout;
  assign bus.BAout = w_c.baout;     assign bus.Rout = w_c.rout;
  assign bus.MARin = w_c.marin;     assign bus.MDRin = w_c.mdrin;
  assign bus.IRin = w_c.irin;       assign bus.Yin = w_c.yin;
  assign bus.Zin = w_c.zin;         assign bus.PCin = w_c.pcin;
  assign bus.HIin = w_c.hiin;       assign bus.LOin = w_c.loin;
  assign bus.Rin = w_c.rin;         assign bus.CONin = w_c.conin;
  assign bus.OutPortin = w_c.outportin;
  assign bus.Gra = w_c.gra;         assign bus.Grb = w_c.grb;
  assign bus.Grc = w_c.grc;         assign bus.IncPC = w_c.incpc;
  assign bus.Read = w_c.read;       assign bus.Write = w_c.write;
  assign bus.operation = w_c.op[OPW-1:0];
  assign bus.Run = w_c.run;

  assign w_drv = {w_c.pcout, w_c.zlowout, w_c.zhighout, w_c.mdrout, w_c.hiout,
                  w_c.loout, w_c.cout, w_c.inportout, w_c.baout, w_c.rout};

  // never more than one bus driver; idle states (RESET/HALT/STOPPED, nop) drive none
  always_ff @(posedge Clock) begin
    if (!Reset) a_one_driver: assert ($onehot0(w_drv));
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: a microprogram model pushes the expected control word for
// every cycle; a negedge monitor pops and compares against the DUT outputs.
`timescale 1ns/1ps
module tb_control_sequencer;
  logic Clock, Reset;
  control_sequencer_if #(.IRW(32), .OPW(5)) bus();
  control_sequencer #(.OPW(5), .IRW(32)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // strobe bit positions (bus drivers occupy bits 0..9)
  localparam logic [26:0] B_PCO = 27'd1 << 0,  B_ZLO = 27'd1 << 1,  B_ZHI = 27'd1 << 2,
    B_MDRO = 27'd1 << 3,  B_HIO = 27'd1 << 4,  B_LOO = 27'd1 << 5,  B_CO = 27'd1 << 6,
    B_INO  = 27'd1 << 7,  B_BAO = 27'd1 << 8,  B_RO  = 27'd1 << 9,  B_MARI = 27'd1 << 10,
    B_MDRI = 27'd1 << 11, B_IRI = 27'd1 << 12, B_YI  = 27'd1 << 13, B_ZI = 27'd1 << 14,
    B_PCI  = 27'd1 << 15, B_HII = 27'd1 << 16, B_LOI = 27'd1 << 17, B_RI = 27'd1 << 18,
    B_CONI = 27'd1 << 19, B_OUTI = 27'd1 << 20, B_GRA = 27'd1 << 21, B_GRB = 27'd1 << 22,
    B_GRC  = 27'd1 << 23, B_INC = 27'd1 << 24, B_RD  = 27'd1 << 25, B_WR = 27'd1 << 26;
  localparam logic [4:0] ADD = 5'd3, HALT = 5'd26;

  typedef struct { logic [26:0] s; logic [4:0] o; logic run; string nm; } exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0;

  // Microprogram of one instruction: control word per T-step, returns step count
  function automatic int uprog(input logic [4:0] op, input logic con,
                               output logic [7:0][26:0] s, output logic [7:0][4:0] o);
    s = '0; o = '0;
    s[0] = B_PCO | B_MARI | B_INC | B_ZI;
    s[1] = B_ZLO | B_PCI | B_RD | B_MDRI;
    s[2] = B_MDRO | B_IRI;
    if (op inside {[5'd3:5'd10]}) begin
      s[3] = B_GRB | B_RO | B_YI; s[4] = B_GRC | B_RO | B_ZI; o[4] = op;
      s[5] = B_ZLO | B_GRA | B_RI; return 6;
    end
    if (op == 5'd11 || op == 5'd12) begin
      s[3] = B_GRB | B_RO | B_ZI; o[3] = op; s[4] = B_ZLO | B_GRA | B_RI; return 5;
    end
    if (op inside {5'd0, 5'd1, 5'd2, [5'd13:5'd15]}) begin
      s[3] = B_GRB | B_BAO | B_YI; s[4] = B_CO | B_ZI; o[4] = (op >= 5'd13) ? op : ADD;
      if (op == 5'd0) begin
        s[5] = B_ZLO | B_MARI; s[6] = B_RD | B_MDRI; s[7] = B_MDRO | B_GRA | B_RI; return 8;
      end
      if (op == 5'd2) begin
        s[5] = B_ZLO | B_MARI; s[6] = B_GRA | B_RO | B_MDRI; s[7] = B_WR; return 8;
      end
      s[5] = B_ZLO | B_GRA | B_RI; return 6;
    end
    if (op == 5'd16 || op == 5'd17) begin
      s[3] = B_GRA | B_RO | B_YI; s[4] = B_GRB | B_RO | B_ZI; o[4] = op;
      s[5] = B_ZLO | B_LOI; s[6] = B_ZHI | B_HII; return 7;
    end
    if (op == 5'd18) begin
      s[3] = B_GRA | B_RO | B_CONI; s[4] = B_PCO | B_YI; s[5] = B_CO | B_ZI; o[5] = ADD;
      s[6] = B_ZLO | (con ? B_PCI : 27'd0); return 7;
    end
    if (op == 5'd20) begin
      s[3] = B_PCO | B_RI; s[4] = B_GRA | B_RO | B_PCI; return 5;
    end
    case (op)
      5'd19: s[3] = B_GRA | B_RO | B_PCI;
      5'd21: s[3] = B_INO | B_GRA | B_RI;
      5'd22: s[3] = B_GRA | B_RO | B_OUTI;
      5'd23: s[3] = B_HIO | B_GRA | B_RI;
      5'd24: s[3] = B_LOO | B_GRA | B_RI;
      default: s[3] = '0;
    endcase
    return 4;
  endfunction

  // one clock: apply inputs for this cycle, record what this cycle must show
  task automatic tick(input logic rst, input logic stp, input logic [31:0] ir, input logic con,
                      input logic [26:0] s, input logic [4:0] o, input logic run, input string nm);
    exp_t e;
    @(posedge Clock); #1;
    Reset = rst; bus.Stop = stp; bus.IR = ir; bus.CON_FF = con;
    e.s = s; e.o = o; e.run = run; e.nm = nm;
    sbq.push_back(e);
  endtask

  // run one instruction from T0; Stop high from step stop_t, Reset during step rst_t
  task automatic exec(input logic [31:0] ir, input logic con, input int stop_t,
                      input int rst_t, input string nm);
    logic [7:0][26:0] s; logic [7:0][4:0] o; int n;
    n = uprog(ir[31:27], con, s, o);
    for (int t = 0; t < n; t++) begin
      tick(t == rst_t, t >= stop_t, (t < 3) ? $urandom : ir, con, s[t], o[t], 1'b1,
           $sformatf("%s_T%0d", nm, t));
      if (t == rst_t) begin
        tick(1'b0, 1'b0, ir, con, '0, '0, 1'b1, {nm, "_reset"});
        return;
      end
    end
    if (stop_t < n) begin
      repeat ($urandom_range(1, 3)) tick(1'b0, 1'b1, ir, con, '0, '0, 1'b0, {nm, "_stopped"});
      tick(1'b0, 1'b0, ir, con, '0, '0, 1'b0, {nm, "_stopped"});
    end
  endtask

  // monitor: compare every presented cycle against the scoreboard head
  always @(negedge Clock) begin
    exp_t e; logic [26:0] act;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = {bus.Write, bus.Read, bus.IncPC, bus.Grc, bus.Grb, bus.Gra, bus.OutPortin,
             bus.CONin, bus.Rin, bus.LOin, bus.HIin, bus.PCin, bus.Zin, bus.Yin, bus.IRin,
             bus.MDRin, bus.MARin, bus.Rout, bus.BAout, bus.InPortout, bus.Cout, bus.LOout,
             bus.HIout, bus.MDRout, bus.ZHighout, bus.Zlowout, bus.PCout};
      checks++;
      if (act !== e.s || bus.operation !== e.o || bus.Run !== e.run) begin
        failures++;
        $display("FAIL %s: got strobes=%07h op=%05b run=%b, want strobes=%07h op=%05b run=%b",
                 e.nm, act, bus.operation, bus.Run, e.s, e.o, e.run);
      end
      checks++;
      if (!$onehot0(act[9:0])) begin
        failures++;
        $display("FAIL %s_busdrv: drivers=%03h, want at most one", e.nm, act[9:0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    int st, rt;
    Reset = 1'b1; bus.Stop = 1'b0; bus.IR = '0; bus.CON_FF = 1'b0;
    tick(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1, "reset0");
    tick(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, "reset1");

    exec(32'h0A000054, 1'b0, 8, 8, "ldi");
    exec({5'd18, 27'h0123456}, 1'b0, 8, 8, "br_nt");
    exec({5'd18, 27'h0654321}, 1'b1, 8, 8, "br_t");

    exec({HALT, 27'h0}, 1'b0, 8, 8, "halt");
    repeat (20) tick(1'b0, 1'b0, $urandom, 1'b0, '0, '0, 1'b0, "halted");
    tick(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, "halted_rst");
    tick(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, "halt_reset");

    exec({5'd3, 27'h0111111}, 1'b0, 4, 8, "add_stop");
    exec({5'd0, 27'h0222222}, 1'b0, 8, 6, "ld_rst");
    exec({5'd2, 27'h0333333}, 1'b0, 8, 8, "st");

    for (int i = 0; i < 200; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == HALT) op = 5'd25;
      st = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : 8;
      rt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 8;
      exec({op, 27'($urandom)}, 1'($urandom), st, rt, $sformatf("rnd%0d_op%0d", i, op));
    end

    @(negedge Clock); #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
